fifo_bank_masked: RTL and testbench
===================================

// Module: fifo_bank_masked
// PURPOSE
//  Parametrised bank of NUM_BANKS independent synchronous FIFOs for accelerator input-feature/output-feature buffering.
//  Successor to the shared-control FIFO bank: per-bank write/read masks, per-bank full/empty/count, programmable
//  almost-full/almost-empty thresholds, sticky overflow/underflow errors and a synchronous flush.
//  Sits between the DMA/line-buffer front end and the PE array; one instance per feature stream (IF or OF width).
// PARAMETERS
//  DATA_WIDTH   8   bits per entry (instantiate with 2*DATA_WIDTH for OF banks)
//  DEPTH_WIDTH  2   log2 of entries per bank; DEPTH = 2**DEPTH_WIDTH
//  NUM_BANKS    5   number of independent FIFO banks
//  AF_THRESH    3   almost_full asserted when count >= AF_THRESH (1..DEPTH)
//  AE_THRESH    1   almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)
// PORTS
//  clk           in   1                          clock, all logic on rising edge
//  rst           in   1                          synchronous reset, active-low (rst==0 at posedge resets)
//  flush_i       in   1                          synchronous clear of all banks
//  wr_en_i       in   1                          write strobe, qualified by wr_mask_i
//  wr_mask_i     in   NUM_BANKS                  bank b written when wr_en_i & wr_mask_i[b]
//  wr_data_i     in   DATA_WIDTH x [NUM_BANKS]   write data per bank
//  rd_en_i       in   1                          read strobe, qualified by rd_mask_i
//  rd_mask_i     in   NUM_BANKS                  bank b read when rd_en_i & rd_mask_i[b]
//  rd_data_o     out  DATA_WIDTH x [NUM_BANKS]   registered read data per bank
//  rd_valid_o    out  NUM_BANKS                  1-cycle pulse: rd_data_o[b] updated this cycle
//  count_o       out  (DEPTH_WIDTH+1) x [NUM_BANKS]  occupancy per bank, 0..DEPTH
//  full_o/empty_o          out  NUM_BANKS        per bank: count==DEPTH / count==0
//  almost_full_o/almost_empty_o out NUM_BANKS    per-bank threshold flags
//  any_full_o    out  1                          OR of full_o (shared-control back-pressure)
//  all_empty_o   out  1                          AND of empty_o
//  overflow_o    out  NUM_BANKS                  sticky: write to full bank was rejected
//  underflow_o   out  NUM_BANKS                  sticky: read of empty bank was rejected
// BEHAVIOUR
//  - Reset (rst==0): all counts/pointers 0, rd_data_o=0, rd_valid_o=0, overflow/underflow=0; storage not reset.
//    Hence empty_o='1, full_o=0, all_empty_o=1, any_full_o=0, almost_empty_o='1 (AE_THRESH>=0).
//  - Per bank: wr_ptr/rd_ptr DEPTH_WIDTH bits, wrap DEPTH-1 -> 0; count register DEPTH_WIDTH+1 bits.
//  - Flags are combinational from the count register only (no input-to-output paths).
//  - Read accepted iff rd_en_i & rd_mask_i[b] & !empty_o[b]: rd_data_o[b] <= mem[rd_ptr] at that edge,
//    rd_valid_o[b]=1 for the following cycle, rd_ptr++. Latency: data visible 1 cycle after strobe.
//    rd_data_o[b] holds its value when no read is accepted.
//  - Write accepted iff wr_en_i & wr_mask_i[b] & (!full_o[b] | read accepted on b this cycle).
//    Full bank with simultaneous accepted read: both proceed, count stays DEPTH.
//  - Empty bank with simultaneous write and read: write accepted, read rejected (no bypass), underflow set.
//  - Rejected write -> overflow_o[b] set, data dropped, state unchanged; rejected read -> underflow_o[b] set.
//    Sticky bits clear only on reset or flush.
//  - count: +1 write only, -1 read only, unchanged both/neither.
//  - flush_i=1 (rst=1): pointers, counts, sticky bits, rd_valid_o cleared; rd_data_o holds; wr/rd same cycle ignored.
//  - Reset has priority over flush; flush over wr/rd. Reset mid-transfer discards all contents.
//  - Masked-off banks are completely unaffected by strobes (no flags, no pointer movement).
// TESTING
//  1 Reset: hold rst=0 3 cycles with wr_en_i=1 -> count_o all 0, empty_o=5'h1F, rd_valid_o=0, overflow_o=0.
//  2 Fill bank 2 only: 4 writes 0xA0..0xA3 mask 5'b00100 -> full_o=5'b00100, count_o[2]=4, almost_full_o[2] at count 3;
//    5th write -> overflow_o[2]=1, count stays 4; 4 reads -> rd_data_o[2]=A0,A1,A2,A3 each 1 cycle after strobe.
//  3 Full bank 0, simultaneous wr 0x55 + rd -> rd_data_o[0]=oldest entry, count stays 4, overflow_o[0]=0; drain ends 0x55.
//  4 Empty bank 1, simultaneous wr 0x77 + rd -> count_o[1]=1, underflow_o[1]=1, rd_valid_o[1]=0; next read returns 0x77.
//  5 Pointer wrap: 10 interleaved write/read pairs on all banks -> data order preserved, counts never exceed 1.
//  6 Flush with bank 3 at count 3 and overflow set, wr_en_i=1 same cycle -> count_o[3]=0, overflow_o=0, no write taken.

Source files
------------

// File: rtl/fifo_bank_masked_if.sv
// Write/read handshake bundle shared by the FIFO bank and its producer/consumer.
// The slave side is the FIFO bank; the master side drives strobes, masks and write data.
interface fifo_bank_masked_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_BANKS  = 5
);
  logic                                 wr_en_i;
  logic [NUM_BANKS-1:0]                 wr_mask_i;
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] wr_data_i;
  logic                                 rd_en_i;
  logic [NUM_BANKS-1:0]                 rd_mask_i;
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] rd_data_o;
  logic [NUM_BANKS-1:0]                 rd_valid_o;

  modport slave (
    input  wr_en_i, wr_mask_i, wr_data_i, rd_en_i, rd_mask_i,
    output rd_data_o, rd_valid_o
  );

  modport master (
    output wr_en_i, wr_mask_i, wr_data_i, rd_en_i, rd_mask_i,
    input  rd_data_o, rd_valid_o
  );
endinterface

// File: rtl/fifo_bank_masked.sv
// Bank of independent synchronous FIFOs with per-bank masks, occupancy flags,
// sticky overflow/underflow errors and a synchronous flush.
module fifo_bank_masked #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned DEPTH_WIDTH = 2,
  parameter int unsigned NUM_BANKS   = 5,
  parameter int unsigned AF_THRESH   = 3,
  parameter int unsigned AE_THRESH   = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush_i,
  fifo_bank_masked_if.slave                     bus_io,
  output logic [NUM_BANKS-1:0][DEPTH_WIDTH:0]   count_o,
  output logic [NUM_BANKS-1:0]                  full_o,
  output logic [NUM_BANKS-1:0]                  empty_o,
  output logic [NUM_BANKS-1:0]                  almost_full_o,
  output logic [NUM_BANKS-1:0]                  almost_empty_o,
  output logic                                  any_full_o,
  output logic                                  all_empty_o,
  output logic [NUM_BANKS-1:0]                  overflow_o,
  output logic [NUM_BANKS-1:0]                  underflow_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_WIDTH;

  localparam logic [DEPTH_WIDTH:0]   DepthCnt = (DEPTH_WIDTH + 1)'(DEPTH);
  localparam logic [DEPTH_WIDTH:0]   AfCnt    = (DEPTH_WIDTH + 1)'(AF_THRESH);
  localparam logic [DEPTH_WIDTH:0]   AeCnt    = (DEPTH_WIDTH + 1)'(AE_THRESH);
  localparam logic [DEPTH_WIDTH:0]   CntOne   = (DEPTH_WIDTH + 1)'(1);
  localparam logic [DEPTH_WIDTH-1:0] PtrOne   = DEPTH_WIDTH'(1);

  logic [NUM_BANKS-1:0][DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [NUM_BANKS-1:0][DEPTH_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [NUM_BANKS-1:0][DEPTH_WIDTH:0]   count_q, count_d;
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]  rd_data_q, rd_data_d;
  logic [NUM_BANKS-1:0]                  rd_valid_q, rd_valid_d;
  logic [NUM_BANKS-1:0]                  ovf_q, ovf_d;
  logic [NUM_BANKS-1:0]                  unf_q, unf_d;
  logic [NUM_BANKS-1:0]                  wr_acc, rd_acc, wr_req, rd_req;
  logic [DATA_WIDTH-1:0]                 mem_q [NUM_BANKS][DEPTH];

  // Flags depend only on the count register, never on the strobes.
  always_comb begin
    full_o         = '0;
    empty_o        = '0;
    almost_full_o  = '0;
    almost_empty_o = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      full_o[b]         = (count_q[b] == DepthCnt);
      empty_o[b]        = (count_q[b] == '0);
      almost_full_o[b]  = (count_q[b] >= AfCnt);
      almost_empty_o[b] = (count_q[b] <= AeCnt);
    end
  end

  assign any_full_o        = |full_o;
  assign all_empty_o       = &empty_o;
  assign count_o           = count_q;
  assign overflow_o        = ovf_q;
  assign underflow_o       = unf_q;
  assign bus_io.rd_data_o  = rd_data_q;
  assign bus_io.rd_valid_o = rd_valid_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = '0;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    wr_req     = '0;
    rd_req     = '0;
    wr_acc     = '0;
    rd_acc     = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      wr_req[b] = bus_io.wr_en_i & bus_io.wr_mask_i[b];
      rd_req[b] = bus_io.rd_en_i & bus_io.rd_mask_i[b];
      // A full bank still takes a write when a read frees the slot in the same cycle.
      rd_acc[b] = ~flush_i & rd_req[b] & ~empty_o[b];
      wr_acc[b] = ~flush_i & wr_req[b] & (~full_o[b] | rd_acc[b]);
      if (flush_i) begin
        wr_ptr_d[b] = '0;
        rd_ptr_d[b] = '0;
        count_d[b]  = '0;
        ovf_d[b]    = 1'b0;
        unf_d[b]    = 1'b0;
      end else begin
        if (rd_acc[b]) begin
          rd_data_d[b]  = mem_q[b][rd_ptr_q[b]];
          rd_valid_d[b] = 1'b1;
          rd_ptr_d[b]   = rd_ptr_q[b] + PtrOne;
        end
        if (wr_acc[b]) begin
          wr_ptr_d[b] = wr_ptr_q[b] + PtrOne;
        end
        unique case ({wr_acc[b], rd_acc[b]})
          2'b10:   count_d[b] = count_q[b] + CntOne;
          2'b01:   count_d[b] = count_q[b] - CntOne;
          default: count_d[b] = count_q[b];
        endcase
        if (wr_req[b] && !wr_acc[b]) ovf_d[b] = 1'b1;
        if (rd_req[b] && !rd_acc[b]) unf_d[b] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= '0;
      ovf_q      <= '0;
      unf_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (rst && wr_acc[b]) begin
        mem_q[b][wr_ptr_q[b]] <= bus_io.wr_data_i[b];
      end
    end
  end

endmodule

// File: tb/tb_fifo_bank_masked.sv
// Directed bench for fifo_bank_masked: reset, fill/overflow, full and empty
// simultaneous access, pointer wrap, flush and mid-transfer reset.
module tb_fifo_bank_masked;
  localparam int unsigned DW = 8;
  localparam int unsigned PW = 2;
  localparam int unsigned NB = 5;

  logic clk;
  logic rst;
  logic flush_i;
  logic [NB-1:0][PW:0] count_o;
  logic [NB-1:0] full_o, empty_o, almost_full_o, almost_empty_o, overflow_o, underflow_o;
  logic any_full_o, all_empty_o;

  int checks = 0;
  int errors = 0;

  fifo_bank_masked_if #(.DATA_WIDTH(DW), .NUM_BANKS(NB)) bus ();

  fifo_bank_masked #(
    .DATA_WIDTH (DW),
    .DEPTH_WIDTH(PW),
    .NUM_BANKS  (NB),
    .AF_THRESH  (3),
    .AE_THRESH  (1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (flush_i),
    .bus_io        (bus),
    .count_o       (count_o),
    .full_o        (full_o),
    .empty_o       (empty_o),
    .almost_full_o (almost_full_o),
    .almost_empty_o(almost_empty_o),
    .any_full_o    (any_full_o),
    .all_empty_o   (all_empty_o),
    .overflow_o    (overflow_o),
    .underflow_o   (underflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [NB-1:0][DW-1:0] ev;
  logic [NB-1:0][PW:0]   ones_cnt;
  logic [DW-1:0]         drain_exp [4];

  initial begin
    rst           = 1'b0;
    flush_i       = 1'b0;
    bus.wr_en_i   = 1'b1;
    bus.wr_mask_i = '1;
    bus.wr_data_i = '1;
    bus.rd_en_i   = 1'b0;
    bus.rd_mask_i = '0;
    for (int i = 0; i < NB; i++) ones_cnt[i] = 3'd1;

    // Reset held with write strobe active.
    repeat (3) step();
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_empty", 64'(empty_o), 64'h1F);
    check("rst_full", 64'(full_o), 64'h0);
    check("rst_valid", 64'(bus.rd_valid_o), 64'h0);
    check("rst_ovf", 64'(overflow_o), 64'h0);
    check("rst_all_empty", 64'(all_empty_o), 64'd1);
    check("rst_any_full", 64'(any_full_o), 64'd0);
    check("rst_almost_empty", 64'(almost_empty_o), 64'h1F);
    check("rst_rd_data", 64'(bus.rd_data_o), 64'h0);
    rst         = 1'b1;
    bus.wr_en_i = 1'b0;

    // Fill bank 2 only.
    bus.wr_en_i   = 1'b1;
    bus.wr_mask_i = 5'b00100;
    for (int i = 0; i < 4; i++) begin
      bus.wr_data_i[2] = 8'hA0 + 8'(i);
      step();
      check("fill_count2", 64'(count_o[2]), 64'(i + 1));
      check("fill_af2", 64'(almost_full_o[2]), 64'(i >= 2));
    end
    check("fill_full", 64'(full_o), 64'b00100);
    check("fill_any_full", 64'(any_full_o), 64'd1);
    check("fill_count0", 64'(count_o[0]), 64'd0);
    bus.wr_data_i[2] = 8'hEE;
    step();
    check("ovf_flag", 64'(overflow_o), 64'b00100);
    check("ovf_count2", 64'(count_o[2]), 64'd4);
    bus.wr_en_i   = 1'b0;
    bus.rd_en_i   = 1'b1;
    bus.rd_mask_i = 5'b00100;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rd2_valid", 64'(bus.rd_valid_o), 64'b00100);
      check("rd2_data", 64'(bus.rd_data_o[2]), 64'(8'hA0 + 8'(i)));
      check("rd2_count", 64'(count_o[2]), 64'(3 - i));
    end
    bus.rd_en_i = 1'b0;
    step();
    check("rd2_valid_drop", 64'(bus.rd_valid_o), 64'h0);
    check("rd2_empty", 64'(empty_o), 64'h1F);
    check("rd2_no_unf", 64'(underflow_o), 64'h0);
    check("rd2_hold", 64'(bus.rd_data_o[2]), 64'hA3);

    // Full bank 0 with simultaneous write and read.
    bus.wr_en_i   = 1'b1;
    bus.wr_mask_i = 5'b00001;
    for (int i = 0; i < 4; i++) begin
      bus.wr_data_i[0] = 8'h10 + 8'(i);
      step();
    end
    check("b0_full", 64'(full_o[0]), 64'd1);
    bus.wr_data_i[0] = 8'h55;
    bus.rd_en_i      = 1'b1;
    bus.rd_mask_i    = 5'b00001;
    step();
    check("fullrw_data", 64'(bus.rd_data_o[0]), 64'h10);
    check("fullrw_valid", 64'(bus.rd_valid_o), 64'b00001);
    check("fullrw_count", 64'(count_o[0]), 64'd4);
    check("fullrw_ovf0", 64'(overflow_o[0]), 64'd0);
    bus.wr_en_i  = 1'b0;
    drain_exp[0] = 8'h11;
    drain_exp[1] = 8'h12;
    drain_exp[2] = 8'h13;
    drain_exp[3] = 8'h55;
    for (int i = 0; i < 4; i++) begin
      step();
      check("drain0_data", 64'(bus.rd_data_o[0]), 64'(drain_exp[i]));
    end
    bus.rd_en_i = 1'b0;
    step();
    check("drain0_empty", 64'(empty_o[0]), 64'd1);

    // Empty bank 1 with simultaneous write and read: no bypass.
    bus.wr_en_i      = 1'b1;
    bus.wr_mask_i    = 5'b00010;
    bus.wr_data_i[1] = 8'h77;
    bus.rd_en_i      = 1'b1;
    bus.rd_mask_i    = 5'b00010;
    step();
    check("emptyrw_count", 64'(count_o[1]), 64'd1);
    check("emptyrw_unf", 64'(underflow_o), 64'b00010);
    check("emptyrw_valid", 64'(bus.rd_valid_o), 64'h0);
    bus.wr_en_i = 1'b0;
    step();
    check("b1_data", 64'(bus.rd_data_o[1]), 64'h77);
    check("b1_valid", 64'(bus.rd_valid_o), 64'b00010);
    check("b1_unf_sticky", 64'(underflow_o[1]), 64'd1);
    bus.rd_en_i = 1'b0;

    // Ten write/read pairs on all banks; pointers wrap.
    for (int i = 0; i < 10; i++) begin
      for (int b = 0; b < NB; b++) begin
        ev[b]            = 8'(i * 16 + b);
        bus.wr_data_i[b] = ev[b];
      end
      bus.wr_en_i   = 1'b1;
      bus.wr_mask_i = '1;
      bus.rd_en_i   = 1'b0;
      step();
      check("wrap_count1", 64'(count_o), 64'(ones_cnt));
      bus.wr_en_i   = 1'b0;
      bus.rd_en_i   = 1'b1;
      bus.rd_mask_i = '1;
      step();
      check("wrap_data", 64'(bus.rd_data_o), 64'(ev));
      check("wrap_count0", 64'(count_o), 64'd0);
    end
    bus.rd_en_i = 1'b0;

    // Bank 3 to count 3 with overflow set, then flush with a write pending.
    bus.wr_en_i   = 1'b1;
    bus.wr_mask_i = 5'b01000;
    for (int i = 0; i < 5; i++) begin
      bus.wr_data_i[3] = 8'h30 + 8'(i);
      step();
    end
    check("b3_ovf", 64'(overflow_o[3]), 64'd1);
    bus.wr_en_i   = 1'b0;
    bus.rd_en_i   = 1'b1;
    bus.rd_mask_i = 5'b01000;
    step();
    check("b3_rd", 64'(bus.rd_data_o[3]), 64'h30);
    check("b3_count", 64'(count_o[3]), 64'd3);
    bus.rd_en_i   = 1'b0;
    flush_i       = 1'b1;
    bus.wr_en_i   = 1'b1;
    bus.wr_mask_i = '1;
    bus.wr_data_i = '1;
    step();
    check("flush_count", 64'(count_o), 64'd0);
    check("flush_ovf", 64'(overflow_o), 64'h0);
    check("flush_unf", 64'(underflow_o), 64'h0);
    check("flush_valid", 64'(bus.rd_valid_o), 64'h0);
    check("flush_hold", 64'(bus.rd_data_o[3]), 64'h30);
    flush_i     = 1'b0;
    bus.wr_en_i = 1'b0;
    step();
    check("flush_nowrite", 64'(count_o), 64'd0);
    check("flush_all_empty", 64'(all_empty_o), 64'd1);

    // Reset mid-transfer discards contents.
    bus.wr_en_i   = 1'b1;
    bus.wr_mask_i = 5'b00001;
    step();
    check("pre_rst_count", 64'(count_o[0]), 64'd1);
    check("pre_rst_ae", 64'(almost_empty_o[0]), 64'd1);
    rst = 1'b0;
    step();
    check("mid_rst_count", 64'(count_o), 64'd0);
    rst         = 1'b1;
    bus.wr_en_i = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end
endmodule
